// File: rtl/prio_arb_pkg.sv
// Shared types and constants for the prio_arbiter_rr grant FSM.
// Imported by the arbiter top level.
package prio_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage : prio_arb_pkg

// File: rtl/prio_pick.sv
// Combinational highest-set-bit encoder.
// Reports whether any bit is set and the index of the most significant one.
module prio_pick #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Ascending scan, so the last set bit seen (the highest) wins.
  always_comb begin
    found = 1'b0;
    idx   = {IDX_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      found = found | vec[i];
      idx   = vec[i] ? IDX_W'(i) : idx;
    end
  end

endmodule : prio_pick

// File: rtl/prio_arbiter_rr.sv
// N-input arbiter, fixed (MSB wins) or round-robin priority, with a registered
// grant that is held until the consumer acknowledges it.
module prio_arbiter_rr
  import prio_arb_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             mode,
  input  logic             ack,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N-1:0]     gnt_oh,
  output logic             busy
);

  function automatic logic [N-1:0] below_mask(input logic [IDX_W-1:0] p);
    below_mask = ~({N{1'b1}} << p);
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] p);
    onehot = {{(N-1){1'b0}}, 1'b1} << p;
  endfunction

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_ptr, w_ptr_next, w_ptr_sel;
  logic             r_gnt_valid, w_gnt_valid_next;
  logic [IDX_W-1:0] r_gnt_idx, w_gnt_idx_next;
  logic [N-1:0]     r_gnt_oh, w_gnt_oh_next;

  logic [N-1:0]     w_masked_req;
  logic             w_masked_found, w_any_req;
  logic [IDX_W-1:0] w_masked_idx, w_top_idx, w_win_idx;

  // In the ack cycle the pointer is about to become gnt_idx; pick against that.
  always_comb begin
    if (r_state == GRANT && ack) begin
      w_ptr_sel = r_gnt_idx;
    end else begin
      w_ptr_sel = r_ptr;
    end
  end

  assign w_masked_req = req & below_mask(w_ptr_sel);

  prio_pick #(.N(N), .IDX_W(IDX_W)) u_pick_masked (
    .vec   (w_masked_req),
    .found (w_masked_found),
    .idx   (w_masked_idx)
  );

  prio_pick #(.N(N), .IDX_W(IDX_W)) u_pick_all (
    .vec   (req),
    .found (w_any_req),
    .idx   (w_top_idx)
  );

  assign w_win_idx = (mode == MODE_RR && w_masked_found) ? w_masked_idx : w_top_idx;

  // Next-state and next-output logic; outputs hold unless a grant is issued or retired.
  always_comb begin
    w_state_next     = r_state;
    w_ptr_next       = r_ptr;
    w_gnt_valid_next = r_gnt_valid;
    w_gnt_idx_next   = r_gnt_idx;
    w_gnt_oh_next    = r_gnt_oh;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_next     = GRANT;
          w_gnt_valid_next = 1'b1;
          w_gnt_idx_next   = w_win_idx;
          w_gnt_oh_next    = onehot(w_win_idx);
        end else begin
          w_state_next     = IDLE;
        end
      end
      GRANT: begin
        if (ack) begin
          w_ptr_next = r_gnt_idx;
          if (w_any_req) begin
            w_state_next     = GRANT;
            w_gnt_valid_next = 1'b1;
            w_gnt_idx_next   = w_win_idx;
            w_gnt_oh_next    = onehot(w_win_idx);
          end else begin
            w_state_next     = IDLE;
            w_gnt_valid_next = 1'b0;
            w_gnt_idx_next   = {IDX_W{1'b0}};
            w_gnt_oh_next    = {N{1'b0}};
          end
        end else begin
          w_state_next = GRANT;
        end
      end
      default: begin
        w_state_next     = IDLE;
        w_gnt_valid_next = 1'b0;
        w_gnt_idx_next   = {IDX_W{1'b0}};
        w_gnt_oh_next    = {N{1'b0}};
      end
    endcase
  end

  // State, pointer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= {IDX_W{1'b0}};
      r_gnt_valid <= 1'b0;
      r_gnt_idx   <= {IDX_W{1'b0}};
      r_gnt_oh    <= {N{1'b0}};
    end else begin
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_gnt_valid <= w_gnt_valid_next;
      r_gnt_idx   <= w_gnt_idx_next;
      r_gnt_oh    <= w_gnt_oh_next;
    end
  end

  assign gnt_valid = r_gnt_valid;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_oh    = r_gnt_oh;
  assign busy      = r_gnt_valid;

endmodule : prio_arbiter_rr

// File: tb/tb_prio_arbiter_rr.sv
// Self-checking bench for prio_arbiter_rr: directed scenarios plus randomized
// traffic, all compared against a behavioural grant model.
module tb_prio_arbiter_rr;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic             mode;
  logic             ack;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic [N-1:0]     gnt_oh;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit m_valid = 1'b0;
  int m_idx   = 0;
  int m_ptr   = 0;

  prio_arbiter_rr #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mode      (mode),
    .ack       (ack),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .gnt_oh    (gnt_oh),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_pick(input logic [N-1:0] r, input logic m, input int p);
    if (m) begin
      for (int i = p - 1; i >= 0; i--) if (r[i]) return i;
    end
    for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    return 0;
  endfunction

  task automatic step(input logic s_rst, input logic [N-1:0] s_req, input logic s_mode, input logic s_ack);
    logic [31:0] exp_oh;
    rst  = s_rst;
    req  = s_req;
    mode = s_mode;
    ack  = s_ack;
    @(posedge clk);
    if (s_rst) begin
      m_valid = 1'b0; m_idx = 0; m_ptr = 0;
    end else if (!m_valid) begin
      if (s_req != '0) begin
        m_valid = 1'b1;
        m_idx   = ref_pick(s_req, s_mode, m_ptr);
      end
    end else if (s_ack) begin
      m_ptr = m_idx;
      if (s_req != '0) m_idx = ref_pick(s_req, s_mode, m_ptr);
      else begin
        m_valid = 1'b0; m_idx = 0;
      end
    end
    #1;
    exp_oh = m_valid ? (32'd1 << m_idx) : 32'd0;
    check_eq("gnt_valid", {31'd0, gnt_valid}, {31'd0, m_valid});
    check_eq("gnt_idx",   {29'd0, gnt_idx}, m_idx);
    check_eq("gnt_oh",    {24'd0, gnt_oh}, exp_oh);
    check_eq("busy",      {31'd0, busy}, {31'd0, m_valid});
  endtask

  initial begin
    rst = 1'b1; req = '0; mode = 1'b0; ack = 1'b0;

    // 1: reset dominates a fully loaded request vector
    step(1'b1, 8'hFF, 1'b1, 1'b1);
    step(1'b1, 8'hFF, 1'b1, 1'b1);
    check_eq("t1_reset_valid", {31'd0, gnt_valid}, 32'd0);
    step(1'b0, 8'hFF, 1'b1, 1'b1);
    check_eq("t1_first_grant", {29'd0, gnt_idx}, 32'd7);

    // 2: fixed priority repeats the top requester
    step(1'b1, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'b0010_1100, 1'b0, 1'b1);
      check_eq("t2_fixed_5", {29'd0, gnt_idx}, 32'd5);
    end
    step(1'b0, 8'h01, 1'b0, 1'b1);
    check_eq("t2_grant_0", {29'd0, gnt_idx}, 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("t2_valid_fall", {31'd0, gnt_valid}, 32'd0);

    // 3: round-robin sweep with all requesting, no bubbles
    step(1'b1, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 8'hFF, 1'b1, 1'b1);
      check_eq("t3_rr_idx", {29'd0, gnt_idx}, 32'((7 - k + 8) % 8));
      check_eq("t3_rr_valid", {31'd0, gnt_valid}, 32'd1);
    end

    // 4: two requesters alternate, then a sole requester equal to ptr repeats
    step(1'b1, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 8'b1000_0010, 1'b1, 1'b1);
      check_eq("t4_alt", {29'd0, gnt_idx}, (k % 2 == 0) ? 32'd7 : 32'd1);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'h02, 1'b1, 1'b1);
      check_eq("t4_sole", {29'd0, gnt_idx}, 32'd1);
    end

    // 5: grant frozen while unacknowledged, even after the request drops
    step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h10, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_eq("t5_hold_oh", {24'd0, gnt_oh}, 32'h10);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("t5_ack_clear", {31'd0, gnt_valid}, 32'd0);

    // 6: reset in the middle of a grant clears outputs and the pointer
    step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h40, 1'b0, 1'b0);
    check_eq("t6_grant_6", {29'd0, gnt_idx}, 32'd6);
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    check_eq("t6_reset_oh", {24'd0, gnt_oh}, 32'd0);
    step(1'b0, 8'hFF, 1'b1, 1'b0);
    check_eq("t6_after_rst", {29'd0, gnt_idx}, 32'd7);

    // Randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      logic [N-1:0] r_req;
      logic         r_rst;
      r_rst = ($urandom_range(0, 60) == 0);
      case ($urandom_range(0, 3))
        0:       r_req = 8'h00;
        1:       r_req = 8'(1 << $urandom_range(0, 7));
        default: r_req = 8'($urandom);
      endcase
      step(r_rst, r_req, 1'($urandom), ($urandom_range(0, 9) < 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_prio_arbiter_rr
